// File: rtl/snn_psum_adder_if.sv
// Packet-in / result-out handshake bundle for the SNN partial-sum adder.
interface snn_psum_adder_if #(
  parameter int PACKET_WIDTH = 39
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PACKET_WIDTH-1:0] in_packet;
  logic                    out_valid;
  logic                    out_ready;
  logic [PACKET_WIDTH-1:0] out_packet;
  logic                    err_pulse;

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_packet, err_pulse
  );

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_packet, err_pulse
  );
endinterface

// File: rtl/snn_psum_adder.sv
// Collects one 3-element psum per PE, adds the carried residues, thresholds the sums into spikes
// and emits one result packet per round. Result valid two edges after the last psum; held until out_ready.
module snn_psum_adder #(
  parameter int         PACKET_WIDTH = 39,
  parameter int         NUM_PE       = 3,
  parameter int         PE_BASE      = 1,
  parameter logic [3:0] NODE_ADDR    = 4'd8,
  parameter logic [3:0] MEM_ADDR     = 4'd0,
  parameter logic [7:0] THRESH       = 8'd64
) (
  input logic              clk,
  input logic              rst_n,
  snn_psum_adder_if.slave  bus
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_FIRE    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PSUM  = 2'b10;

  localparam logic [3:0] PE_LO = 4'(PE_BASE);
  localparam logic [3:0] PE_HI = 4'(PE_BASE + NUM_PE - 1);

  logic [1:0]        state;
  logic [NUM_PE-1:0] mask;
  logic [9:0]        acc [3];
  logic [7:0]        res [3];
  logic [7:0]        round_cnt;
  logic              rdy_en;
  logic              out_valid_q;
  logic [38:0]       out_packet_q;
  logic              err_q;

  logic [3:0]        dest;
  logic [3:0]        src;
  logic [1:0]        op;
  logic [7:0]        elem [3];
  logic [3:0]        pe_off;
  logic [NUM_PE-1:0] pe_bit;
  logic              in_range;
  logic              is_drop;
  logic              is_psum;
  logic              is_clear;
  logic              stall;
  logic              accept;

  logic [9:0]        sum     [3];
  logic [9:0]        diff    [3];
  logic [7:0]        new_res [3];
  logic [2:0]        spikes;

  logic              unused_ok;

  assign dest     = bus.in_packet[PACKET_WIDTH-1 -: 4];
  assign src      = bus.in_packet[PACKET_WIDTH-5 -: 4];
  assign op       = bus.in_packet[PACKET_WIDTH-9 -: 2];
  assign pe_off   = src - PE_LO;
  assign in_range = (src >= PE_LO) && (src <= PE_HI);

  // Misaddressed, illegal-op and out-of-range psums are swallowed and flagged.
  assign is_drop  = (dest != NODE_ADDR) || op[0] || ((op == OP_PSUM) && !in_range);
  assign is_psum  = !is_drop && (op == OP_PSUM);
  assign is_clear = !is_drop && (op == OP_CLEAR);
  assign stall    = (is_psum && |(mask & pe_bit)) || (is_clear && |mask);

  assign bus.in_ready   = rdy_en && (state == S_COLLECT) && !(bus.in_valid && stall);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_packet = out_packet_q;
  assign bus.err_pulse  = err_q;

  assign unused_ok = ^{bus.in_packet[28:24], round_cnt};

  always_comb begin
    pe_bit = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (pe_off == 4'(i)) pe_bit[i] = 1'b1;
    end
  end

  always_comb begin
    spikes = '0;
    for (int k = 0; k < 3; k++) begin
      elem[k] = bus.in_packet[8*k +: 8];
      sum[k]  = acc[k] + {2'b00, res[k]};
      if (sum[k] >= {2'b00, THRESH}) begin
        spikes[k] = 1'b1;
        diff[k]   = sum[k] - {2'b00, THRESH};
      end else begin
        diff[k]   = sum[k];
      end
      new_res[k] = (diff[k] > 10'd255) ? 8'hFF : diff[k][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_COLLECT;
      mask         <= '0;
      round_cnt    <= '0;
      rdy_en       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        acc[k] <= '0;
        res[k] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      err_q  <= accept && is_drop;
      case (state)
        S_COLLECT: begin
          if (accept && is_psum) begin
            mask <= mask | pe_bit;
            for (int k = 0; k < 3; k++) acc[k] <= acc[k] + {2'b00, elem[k]};
          end
          if (accept && is_clear) begin
            for (int k = 0; k < 3; k++) res[k] <= '0;
          end
          if (&mask) state <= S_FIRE;
        end
        S_FIRE: begin
          out_packet_q <= {MEM_ADDR, NODE_ADDR, 2'b11, 2'b00, spikes,
                           new_res[2], new_res[1], new_res[0]};
          out_valid_q  <= 1'b1;
          mask         <= '0;
          for (int k = 0; k < 3; k++) begin
            res[k] <= new_res[k];
            acc[k] <= '0;
          end
          state <= S_SEND;
        end
        S_SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            round_cnt   <= round_cnt + 8'd1;
            state       <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_psum_adder.sv
// Directed bench for snn_psum_adder: hand-computed result packets across rounds with carried residues.
module tb_snn_psum_adder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  snn_psum_adder_if #(.PACKET_WIDTH(39)) bus ();

  snn_psum_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [38:0] pkt(input logic [3:0] dest, input logic [3:0] src,
                                      input logic [1:0] op, input logic [7:0] p2,
                                      input logic [7:0] p1, input logic [7:0] p0);
    return {dest, src, op, 5'd0, p2, p1, p0};
  endfunction

  function automatic logic [38:0] psum(input logic [3:0] src, input logic [7:0] p2,
                                       input logic [7:0] p1, input logic [7:0] p0);
    return pkt(4'd8, src, 2'b10, p2, p1, p0);
  endfunction

  function automatic logic [38:0] res_pkt(input logic [2:0] sp, input logic [7:0] r2,
                                          input logic [7:0] r1, input logic [7:0] r0);
    return {4'd0, 4'd8, 2'b11, 2'b00, sp, r2, r1, r0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a packet from negedge+1 and hold it until accepted (bounded).
  task automatic send(input string tag, input logic [38:0] p);
    int waited = 0;
    bus.in_valid  = 1'b1;
    bus.in_packet = p;
    #1;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    chk(tag, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic wait_out(input string tag);
    int waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    chk(tag, bus.out_valid, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",   bus.in_ready,   0);
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_packet", bus.out_packet, 0);
    chk("rst_err_pulse",  bus.err_pulse,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", bus.in_ready, 0);
    @(negedge clk); #1;
    chk("ready_after_first_edge", bus.in_ready, 1);

    // Round A: 90/60/0 -> only element 0 fires, residues 26/60/0; exact latency
    bus.out_ready = 1'b1;
    send("a_pe1", psum(4'd1, 8'd0, 8'd20, 8'd30));
    send("a_pe2", psum(4'd2, 8'd0, 8'd20, 8'd30));
    send("a_pe3", psum(4'd3, 8'd0, 8'd20, 8'd30));
    chk("a_valid_at_n", bus.out_valid, 0);
    @(negedge clk); #1;
    chk("a_valid_in_fire", bus.out_valid, 0);
    chk("a_ready_in_fire", bus.in_ready, 0);
    @(negedge clk); #1;
    chk("a_valid_at_n2", bus.out_valid, 1);
    chk("a_packet", bus.out_packet, res_pkt(3'b001, 8'd0, 8'd60, 8'd26));
    @(negedge clk); #1;
    chk("a_valid_done", bus.out_valid, 0);
    chk("a_ready_back", bus.in_ready, 1);

    // Clear residues, then round B with a duplicate PE2 psum
    send("clear_empty", pkt(4'd8, 4'd0, 2'b00, 8'd0, 8'd0, 8'd0));
    send("b_pe2a", psum(4'd2, 8'd0, 8'd0, 8'd10));
    bus.in_valid  = 1'b1;
    bus.in_packet = psum(4'd2, 8'd0, 8'd0, 8'd40);
    #1;
    chk("b_dup_stall", bus.in_ready, 0);
    @(negedge clk); #1;
    chk("b_dup_stall_held", bus.in_ready, 0);
    chk("b_dup_no_err", bus.err_pulse, 0);
    bus.in_packet = pkt(4'd8, 4'd0, 2'b00, 8'd0, 8'd0, 8'd0);
    #1;
    chk("b_clear_stall", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    send("b_pe1", psum(4'd1, 8'd0, 8'd0, 8'd10));
    send("b_pe3", psum(4'd3, 8'd0, 8'd0, 8'd10));
    bus.in_valid  = 1'b1;
    bus.in_packet = psum(4'd2, 8'd0, 8'd0, 8'd40);
    #1;
    chk("b_dup_full_mask", bus.in_ready, 0);
    @(negedge clk); #1;
    chk("b_dup_fire", bus.in_ready, 0);
    @(negedge clk); #1;
    chk("b1_valid", bus.out_valid, 1);
    chk("b1_packet", bus.out_packet, res_pkt(3'b000, 8'd0, 8'd0, 8'd30));
    chk("b_dup_send", bus.in_ready, 0);
    @(negedge clk); #1;
    chk("b_dup_next_round", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    send("b2_pe1", psum(4'd1, 8'd0, 8'd0, 8'd0));
    send("b2_pe3", psum(4'd3, 8'd0, 8'd0, 8'd0));
    wait_out("b2_valid");
    chk("b2_packet", bus.out_packet, res_pkt(3'b001, 8'd0, 8'd0, 8'd6));
    @(negedge clk); #1;

    // Dropped packets: bad src, illegal op, wrong dest
    send("c_src7", pkt(4'd8, 4'd7, 2'b10, 8'd0, 8'd0, 8'd100));
    chk("c_src7_err", bus.err_pulse, 1);
    @(negedge clk); #1;
    chk("c_src7_err_end", bus.err_pulse, 0);
    send("c_op01", pkt(4'd8, 4'd1, 2'b01, 8'd0, 8'd0, 8'd100));
    chk("c_op01_err", bus.err_pulse, 1);
    @(negedge clk); #1;
    chk("c_op01_err_end", bus.err_pulse, 0);
    send("c_dest5", pkt(4'd5, 4'd2, 2'b10, 8'd0, 8'd0, 8'd100));
    chk("c_dest_err", bus.err_pulse, 1);
    @(negedge clk); #1;
    chk("c_dest_err_end", bus.err_pulse, 0);
    send("c_pe1", psum(4'd1, 8'd0, 8'd0, 8'd10));
    chk("c_good_no_err", bus.err_pulse, 0);
    send("c_pe2", psum(4'd2, 8'd0, 8'd0, 8'd10));
    send("c_pe3", psum(4'd3, 8'd0, 8'd0, 8'd10));
    wait_out("c_valid");
    chk("c_packet", bus.out_packet, res_pkt(3'b000, 8'd0, 8'd0, 8'd36));
    @(negedge clk); #1;

    // Saturation round with a 10-cycle output stall
    bus.out_ready = 1'b0;
    send("d_pe1", psum(4'd1, 8'd255, 8'd255, 8'd255));
    send("d_pe2", psum(4'd2, 8'd255, 8'd255, 8'd255));
    send("d_pe3", psum(4'd3, 8'd255, 8'd255, 8'd255));
    wait_out("d_valid");
    chk("d_packet", bus.out_packet, res_pkt(3'b111, 8'd255, 8'd255, 8'd255));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("d_hold_valid", bus.out_valid, 1);
      chk("d_hold_packet", bus.out_packet, res_pkt(3'b111, 8'd255, 8'd255, 8'd255));
      chk("d_hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    chk("d_done_valid", bus.out_valid, 0);
    chk("d_done_ready", bus.in_ready, 1);

    // Reset mid-collect discards partial round and residues
    send("e_pe1", psum(4'd1, 8'd0, 8'd0, 8'd50));
    send("e_pe2", psum(4'd2, 8'd0, 8'd0, 8'd50));
    rst_n = 1'b0;
    #1;
    chk("e_rst_valid",  bus.out_valid,  0);
    chk("e_rst_packet", bus.out_packet, 0);
    chk("e_rst_ready",  bus.in_ready,   0);
    chk("e_rst_err",    bus.err_pulse,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    send("e2_pe1", psum(4'd1, 8'd0, 8'd0, 8'd20));
    send("e2_pe2", psum(4'd2, 8'd0, 8'd0, 8'd20));
    send("e2_pe3", psum(4'd3, 8'd0, 8'd0, 8'd20));
    wait_out("e2_valid");
    chk("e2_packet", bus.out_packet, res_pkt(3'b000, 8'd0, 8'd0, 8'd60));
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
